reflet_periph_word_bridge: RTL and testbench

Sequential bridge between the CPU's word-wide data port and the byte-wide peripheral bus, which is shared by the hardware-info, GPIO, timer, UART, PWM and segment blocks. Each CPU access is split into consecutive single-byte peripheral cycles at increasing addresses. Read bytes are gathered from the OR-combined peripheral `data_out` bus and assembled into one word. Completion is signalled to the CPU with a one-cycle ready pulse.

---
 rtl/reflet_pkg.sv | 19 +
 rtl/reflet_periph_word_bridge.sv | 130 +++++++++++++
 tb/tb_reflet_periph_word_bridge.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/reflet_pkg.sv
// Shared definitions for the reflet peripheral word bridge.
//   - FSM state encoding (2 bits): IDLE = 0, XFER = 1, DONE = 2
//   - cnt_width(): byte-counter width for a given CPU word width,
//     clog2(wordsize/8) with a minimum of 1 bit.
package reflet_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int cnt_width(input int wordsize);
    int nbytes;
    int w;
    nbytes = wordsize / 8;
    w      = $clog2(nbytes);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/reflet_periph_word_bridge.sv
// Sequential word-to-byte bridge between the CPU data port and the shared
// byte-wide peripheral bus. Each CPU access becomes N = wordsize/8 single-byte
// peripheral cycles at increasing (wrapping) addresses, little-endian, then a
// one-cycle cpu_ready pulse.
//
// Optional feature: define REFLET_PERIPH_BRIDGE_BYTE_ACCESS_EN to add the
// cpu_byte_mode input (single-byte access, zero-extended reads).
//
// Ports:
//   clk             : clock, rising edge
//   reset           : synchronous, active-low
//   cpu_enable      : access request, sampled in IDLE only
//   cpu_write_en    : 1 = write, 0 = read (latched at accept)
//   cpu_byte_mode   : (optional) byte-only access (latched at accept)
//   cpu_addr        : address of byte 0 (latched at accept)
//   cpu_data_in     : write data (latched at accept)
//   cpu_data_out    : assembled read word, held until the next read completes
//   cpu_ready       : one-cycle completion pulse
//   periph_enable   : peripheral bus strobe
//   periph_write_en : peripheral write strobe
//   periph_addr     : current byte address
//   periph_data_out : byte being written (0 on reads)
//   periph_data_in  : OR of all peripheral read buses, valid with periph_addr
//
// state | meaning
// IDLE  | bus quiet, waiting for cpu_enable
// XFER  | one peripheral byte cycle per clock, counter k selects the byte
// DONE  | cpu_ready pulse, read word copied to cpu_data_out
module reflet_periph_word_bridge
  import reflet_pkg::*;
#(
  parameter int wordsize       = 16,
  parameter int base_addr_size = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_enable,
  input  logic                      cpu_write_en,
`ifdef REFLET_PERIPH_BRIDGE_BYTE_ACCESS_EN
  input  logic                      cpu_byte_mode,
`endif
  input  logic [base_addr_size-1:0] cpu_addr,
  input  logic [wordsize-1:0]       cpu_data_in,
  output logic [wordsize-1:0]       cpu_data_out,
  output logic                      cpu_ready,
  output logic                      periph_enable,
  output logic                      periph_write_en,
  output logic [base_addr_size-1:0] periph_addr,
  output logic [7:0]                periph_data_out,
  input  logic [7:0]                periph_data_in
);

  localparam int N  = wordsize / 8;
  localparam int CW = cnt_width(wordsize);

  logic [1:0]                state;
  logic [CW-1:0]             k;
  logic [base_addr_size-1:0] lat_addr;
  logic [wordsize-1:0]       lat_data;
  logic                      lat_we;
  logic                      lat_byte;
  logic [wordsize-1:0]       asm_reg;
  logic [wordsize-1:0]       data_out_reg;
  logic                      in_xfer;
  logic                      last_byte;
  logic                      req_byte;

`ifdef REFLET_PERIPH_BRIDGE_BYTE_ACCESS_EN
  assign req_byte = cpu_byte_mode;
`else
  assign req_byte = 1'b0;
`endif

  assign in_xfer   = (state == ST_XFER);
  assign last_byte = (k == CW'(N - 1)) || lat_byte;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      k            <= '0;
      lat_addr     <= '0;
      lat_data     <= '0;
      lat_we       <= 1'b0;
      lat_byte     <= 1'b0;
      asm_reg      <= '0;
      data_out_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu_enable) begin
            lat_addr <= cpu_addr;
            lat_data <= cpu_data_in;
            lat_we   <= cpu_write_en;
            lat_byte <= req_byte;
            k        <= '0;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (!lat_we) begin
            for (int i = 0; i < N; i++) begin
              if (k == CW'(i)) asm_reg[8*i +: 8] <= periph_data_in;
            end
          end
          if (last_byte) begin
            state <= ST_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        ST_DONE: begin
          // Byte-mode reads ignore stale upper assembly bytes.
          if (!lat_we) begin
            data_out_reg <= lat_byte ? wordsize'(asm_reg[7:0]) : asm_reg;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_data_out    = data_out_reg;
  assign cpu_ready       = (state == ST_DONE);
  assign periph_enable   = in_xfer;
  assign periph_write_en = in_xfer & lat_we;
  assign periph_addr     = in_xfer ? (lat_addr + base_addr_size'(k)) : '0;
  assign periph_data_out = (in_xfer && lat_we) ? 8'(lat_data >> {k, 3'b000}) : 8'h00;

endmodule

// File: tb/tb_reflet_periph_word_bridge.sv
// Bench for reflet_periph_word_bridge: a 16-bit and a 32-bit instance share
// clock and reset; a small read-only byte model (0xFF00..0xFF03) drives each
// instance's periph_data_in.
module tb_reflet_periph_word_bridge;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        en16, we16, bm16;
  logic [15:0] addr16, din16, dout16;
  logic        rdy16, pe16, pwe16;
  logic [15:0] pa16;
  logic [7:0]  pdo16, pdi16;

  // 32-bit instance
  logic        en32, we32, bm32;
  logic [15:0] addr32;
  logic [31:0] din32, dout32;
  logic        rdy32, pe32, pwe32;
  logic [15:0] pa32;
  logic [7:0]  pdo32, pdi32;

  function automatic logic [7:0] model(input logic [15:0] a);
    case (a)
      16'hFF00: return 8'h01;
      16'hFF01: return 8'h00;
      16'hFF02: return 8'h7A;
      16'hFF03: return 8'h03;
      default:  return 8'h00;
    endcase
  endfunction

  assign pdi16 = pe16 ? model(pa16) : 8'h00;
  assign pdi32 = pe32 ? model(pa32) : 8'h00;

  reflet_periph_word_bridge #(.wordsize(16), .base_addr_size(16)) dut16 (
    .clk(clk), .reset(reset),
    .cpu_enable(en16), .cpu_write_en(we16),
`ifdef REFLET_PERIPH_BRIDGE_BYTE_ACCESS_EN
    .cpu_byte_mode(bm16),
`endif
    .cpu_addr(addr16), .cpu_data_in(din16), .cpu_data_out(dout16),
    .cpu_ready(rdy16), .periph_enable(pe16), .periph_write_en(pwe16),
    .periph_addr(pa16), .periph_data_out(pdo16), .periph_data_in(pdi16)
  );

  reflet_periph_word_bridge #(.wordsize(32), .base_addr_size(16)) dut32 (
    .clk(clk), .reset(reset),
    .cpu_enable(en32), .cpu_write_en(we32),
`ifdef REFLET_PERIPH_BRIDGE_BYTE_ACCESS_EN
    .cpu_byte_mode(bm32),
`endif
    .cpu_addr(addr32), .cpu_data_in(din32), .cpu_data_out(dout32),
    .cpu_ready(rdy32), .periph_enable(pe32), .periph_write_en(pwe32),
    .periph_addr(pa32), .periph_data_out(pdo32), .periph_data_in(pdi32)
  );

  // View of the selected instance
  logic        sel32;
  logic        v_en, v_we, v_rdy;
  logic [15:0] v_pa;
  logic [7:0]  v_pdo;
  logic [31:0] v_dout;
  always_comb begin
    v_en   = sel32 ? pe32  : pe16;
    v_we   = sel32 ? pwe32 : pwe16;
    v_rdy  = sel32 ? rdy32 : rdy16;
    v_pa   = sel32 ? pa32  : pa16;
    v_pdo  = sel32 ? pdo32 : pdo16;
    v_dout = sel32 ? dout32 : {16'h0, dout16};
  end

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] prev [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drop_en();
    en16 = 1'b0;
    en32 = 1'b0;
  endtask

  typedef struct {
    logic        sel32;
    logic        we;
    logic        bm;
    logic        hold;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  task automatic do_access(input vec_t v);
    int          n;
    logic [31:0] sh;
    logic [31:0] exp_new;
    int          idx;
    idx = v.sel32 ? 1 : 0;
    n   = v.bm ? 1 : (v.sel32 ? 4 : 2);
    sel32 = v.sel32;
    @(negedge clk);
    if (v.sel32) begin
      en32 = 1'b1; we32 = v.we; bm32 = v.bm; addr32 = v.addr; din32 = v.wdata;
    end else begin
      en16 = 1'b1; we16 = v.we; bm16 = v.bm; addr16 = v.addr; din16 = v.wdata[15:0];
    end
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sh = v.wdata >> (8 * k);
      chk("xfer_enable", {31'h0, v_en}, 32'h1);
      chk("xfer_addr", {16'h0, v_pa}, {16'h0, v.addr + 16'(k)});
      chk("xfer_we", {31'h0, v_we}, {31'h0, v.we});
      chk("xfer_wdata", {24'h0, v_pdo}, v.we ? {24'h0, sh[7:0]} : 32'h0);
      chk("xfer_ready_low", {31'h0, v_rdy}, 32'h0);
      if (!v.hold) drop_en();
    end
    @(negedge clk);
    chk("done_ready", {31'h0, v_rdy}, 32'h1);
    chk("done_enable", {31'h0, v_en}, 32'h0);
    chk("done_dout_old", v_dout, prev[idx]);
    drop_en();
    exp_new = v.we ? prev[idx] : v.exp;
    @(negedge clk);
    chk("idle_ready", {31'h0, v_rdy}, 32'h0);
    chk("idle_enable", {31'h0, v_en}, 32'h0);
    chk("dout_new", v_dout, exp_new);
    @(negedge clk);
    chk("no_second_access", {31'h0, v_en}, 32'h0);
    prev[idx] = exp_new;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'hFF00, 32'h0000_0000, 32'h0000_0001};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hFF00, 32'h0000_0000, 32'h037A_0001};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h1000, 32'h0000_BEEF, 32'h0000_0000};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'hFFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'hFF02, 32'h0000_0000, 32'h0000_037A};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'h2000, 32'h1234_5678, 32'h0000_0000};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFE, 32'h0000_0000, 32'h0000_0000};

    sel32 = 1'b0;
    en16 = 0; we16 = 0; bm16 = 0; addr16 = '0; din16 = '0;
    en32 = 0; we32 = 0; bm32 = 0; addr32 = '0; din32 = '0;
    prev[0] = '0;
    prev[1] = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready16", {31'h0, rdy16}, 32'h0);
    chk("rst_enable16", {31'h0, pe16}, 32'h0);
    chk("rst_addr16", {16'h0, pa16}, 32'h0);
    chk("rst_dout16", {16'h0, dout16}, 32'h0);
    chk("rst_enable32", {31'h0, pe32}, 32'h0);
    chk("rst_dout32", dout32, 32'h0);
    chk("rst_wdata32", {24'h0, pdo32}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) do_access(vecs[i]);

    // Reset during XFER k = 1 of a 32-bit read, with cpu_enable held.
    sel32 = 1'b1;
    @(negedge clk);
    en32 = 1'b1; we32 = 1'b0; bm32 = 1'b0; addr32 = 16'hFF00;
    @(negedge clk);
    chk("abort_k0_addr", {16'h0, pa32}, 32'h0000_FF00);
    @(negedge clk);
    chk("abort_k1_addr", {16'h0, pa32}, 32'h0000_FF01);
    reset = 1'b0;
    en32 = 1'b0;
    @(negedge clk);
    chk("abort_enable", {31'h0, pe32}, 32'h0);
    chk("abort_addr", {16'h0, pa32}, 32'h0);
    chk("abort_ready", {31'h0, rdy32}, 32'h0);
    chk("abort_dout32", dout32, 32'h0);
    chk("abort_dout16", {16'h0, dout16}, 32'h0);
    reset = 1'b1;
    prev[0] = '0;
    prev[1] = '0;
    repeat (2) @(negedge clk);
    chk("abort_no_strobe", {31'h0, pe32}, 32'h0);
    chk("abort_no_ready", {31'h0, rdy32}, 32'h0);

    do_access('{1'b1, 1'b0, 1'b0, 1'b0, 16'hFF00, 32'h0, 32'h037A_0001});

`ifdef REFLET_PERIPH_BRIDGE_BYTE_ACCESS_EN
    do_access('{1'b0, 1'b0, 1'b1, 1'b0, 16'hFF02, 32'h0, 32'h0000_007A});
    do_access('{1'b1, 1'b0, 1'b1, 1'b0, 16'hFF02, 32'h0, 32'h0000_007A});
    do_access('{1'b1, 1'b1, 1'b1, 1'b0, 16'h3000, 32'hAABB_CC5A, 32'h0});
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
